// File: rtl/tcm_dport_arbiter.sv
// Two-master arbiter for the TCM data port: CPU data port and DMA/loader share mem_d_*.
// Round-robin grant, locked until acceptance; an in-order id FIFO steers each ack home.
module tcm_dport_arbiter #(
    parameter int OUTSTANDING_DEPTH = 4,
    parameter int TAG_W             = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [31:0]      cpu_d_addr_i,
    input  logic [31:0]      cpu_d_data_wr_i,
    input  logic             cpu_d_rd_i,
    input  logic [3:0]       cpu_d_wr_i,
    input  logic             cpu_d_cacheable_i,
    input  logic             cpu_d_invalidate_i,
    input  logic             cpu_d_writeback_i,
    input  logic             cpu_d_flush_i,
    input  logic [TAG_W-1:0] cpu_d_req_tag_i,
    output logic             cpu_d_accept_o,
    output logic             cpu_d_ack_o,
    output logic             cpu_d_error_o,
    output logic [31:0]      cpu_d_data_rd_o,
    output logic [TAG_W-1:0] cpu_d_resp_tag_o,

    input  logic [31:0]      dma_addr_i,
    input  logic [31:0]      dma_data_wr_i,
    input  logic             dma_rd_i,
    input  logic [3:0]       dma_wr_i,
    output logic             dma_accept_o,
    output logic             dma_ack_o,
    output logic             dma_error_o,
    output logic [31:0]      dma_data_rd_o,

    output logic [31:0]      mem_d_addr_o,
    output logic [31:0]      mem_d_data_wr_o,
    output logic             mem_d_rd_o,
    output logic [3:0]       mem_d_wr_o,
    output logic             mem_d_cacheable_o,
    output logic [TAG_W-1:0] mem_d_req_tag_o,
    output logic             mem_d_invalidate_o,
    output logic             mem_d_writeback_o,
    output logic             mem_d_flush_o,
    input  logic             mem_d_accept_i,
    input  logic             mem_d_ack_i,
    input  logic             mem_d_error_i,
    input  logic [31:0]      mem_d_data_rd_i,
    input  logic [TAG_W-1:0] mem_d_resp_tag_i,

    output logic             protocol_err_o
);

    localparam int PTR_W = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTSTANDING_DEPTH);

    // Requester ids stored in the FIFO and used for rr/owner
    localparam logic ID_CPU = 1'b0;
    localparam logic ID_DMA = 1'b1;

    logic                         cpu_req_s;
    logic                         dma_req_s;
    logic                         winner_s;
    logic                         winner_req_s;
    logic                         fifo_full_s;
    logic                         fifo_empty_s;
    logic                         grant_s;
    logic                         accept_s;
    logic                         push_s;
    logic                         pop_s;
    logic                         head_id_s;

    logic                         lock_q, lock_d;
    logic                         owner_q, owner_d;
    logic                         rr_q, rr_d;
    logic                         protocol_err_q, protocol_err_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [OUTSTANDING_DEPTH-1:0] fifo_q, fifo_d;

    assign cpu_req_s    = cpu_d_rd_i | (|cpu_d_wr_i) | cpu_d_invalidate_i
                        | cpu_d_writeback_i | cpu_d_flush_i;
    assign dma_req_s    = dma_rd_i | (|dma_wr_i);
    assign fifo_full_s  = (count_q == DEPTH_C);
    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    assign head_id_s    = fifo_q[rd_ptr_q];

    // Winner selection: locked owner first, then sole requester, then round-robin
    always_comb begin
        winner_s = ID_CPU;
        if (lock_q) begin
            winner_s = owner_q;
        end else if (cpu_req_s && dma_req_s) begin
            winner_s = rr_q;
        end else if (dma_req_s) begin
            winner_s = ID_DMA;
        end else begin
            winner_s = ID_CPU;
        end
        winner_req_s = (winner_s == ID_DMA) ? dma_req_s : cpu_req_s;
    end

    assign grant_s  = winner_req_s & ~fifo_full_s & ~rst_i;
    assign accept_s = grant_s & mem_d_accept_i;
    assign push_s   = accept_s;
    // An ack arriving with nothing outstanding is dropped, even if an accept happens alongside
    assign pop_s    = mem_d_ack_i & ~fifo_empty_s & ~rst_i;

    // Request mux toward tcm_mem; strobes are qualified by the grant
    always_comb begin
        mem_d_addr_o       = cpu_d_addr_i;
        mem_d_data_wr_o    = cpu_d_data_wr_i;
        mem_d_rd_o         = 1'b0;
        mem_d_wr_o         = 4'b0000;
        mem_d_cacheable_o  = 1'b0;
        mem_d_req_tag_o    = {TAG_W{1'b0}};
        mem_d_invalidate_o = 1'b0;
        mem_d_writeback_o  = 1'b0;
        mem_d_flush_o      = 1'b0;
        if (winner_s == ID_DMA) begin
            mem_d_addr_o    = dma_addr_i;
            mem_d_data_wr_o = dma_data_wr_i;
            if (grant_s) begin
                mem_d_rd_o = dma_rd_i;
                mem_d_wr_o = dma_wr_i;
            end else begin
                mem_d_rd_o = 1'b0;
            end
        end else begin
            mem_d_req_tag_o = cpu_d_req_tag_i;
            if (grant_s) begin
                mem_d_rd_o         = cpu_d_rd_i;
                mem_d_wr_o         = cpu_d_wr_i;
                mem_d_cacheable_o  = cpu_d_cacheable_i;
                mem_d_invalidate_o = cpu_d_invalidate_i;
                mem_d_writeback_o  = cpu_d_writeback_i;
                mem_d_flush_o      = cpu_d_flush_i;
            end else begin
                mem_d_rd_o = 1'b0;
            end
        end
    end

    // Handshake outputs back to each master
    always_comb begin
        cpu_d_accept_o   = accept_s & (winner_s == ID_CPU);
        dma_accept_o     = accept_s & (winner_s == ID_DMA);
        cpu_d_ack_o      = pop_s & (head_id_s == ID_CPU);
        dma_ack_o        = pop_s & (head_id_s == ID_DMA);
        cpu_d_error_o    = cpu_d_ack_o & mem_d_error_i;
        dma_error_o      = dma_ack_o & mem_d_error_i;
        cpu_d_data_rd_o  = mem_d_data_rd_i;
        dma_data_rd_o    = mem_d_data_rd_i;
        cpu_d_resp_tag_o = mem_d_resp_tag_i;
        protocol_err_o   = protocol_err_q;
    end

    // Next-state for arbitration and outstanding-id FIFO
    always_comb begin
        lock_d         = winner_req_s & ~accept_s;
        owner_d        = winner_s;
        rr_d           = rr_q;
        fifo_d         = fifo_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        protocol_err_d = protocol_err_q | (mem_d_ack_i & fifo_empty_s);

        if (accept_s) begin
            rr_d = ~winner_s;
        end else begin
            rr_d = rr_q;
        end

        if (push_s) begin
            fifo_d[wr_ptr_q] = winner_s;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q         <= 1'b0;
            owner_q        <= ID_CPU;
            rr_q           <= ID_CPU;
            protocol_err_q <= 1'b0;
            wr_ptr_q       <= {PTR_W{1'b0}};
            rd_ptr_q       <= {PTR_W{1'b0}};
            count_q        <= {CNT_W{1'b0}};
            fifo_q         <= {OUTSTANDING_DEPTH{1'b0}};
        end else begin
            lock_q         <= lock_d;
            owner_q        <= owner_d;
            rr_q           <= rr_d;
            protocol_err_q <= protocol_err_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            fifo_q         <= fifo_d;
        end
    end

endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// Directed self-checking bench for tcm_dport_arbiter (depth 4, tag width 11).
module tb_tcm_dport_arbiter;

    localparam int TAG_W = 11;

    logic             clk_i;
    logic             rst_i;
    logic [31:0]      cpu_d_addr_i, cpu_d_data_wr_i;
    logic             cpu_d_rd_i;
    logic [3:0]       cpu_d_wr_i;
    logic             cpu_d_cacheable_i, cpu_d_invalidate_i, cpu_d_writeback_i, cpu_d_flush_i;
    logic [TAG_W-1:0] cpu_d_req_tag_i;
    logic             cpu_d_accept_o, cpu_d_ack_o, cpu_d_error_o;
    logic [31:0]      cpu_d_data_rd_o;
    logic [TAG_W-1:0] cpu_d_resp_tag_o;
    logic [31:0]      dma_addr_i, dma_data_wr_i;
    logic             dma_rd_i;
    logic [3:0]       dma_wr_i;
    logic             dma_accept_o, dma_ack_o, dma_error_o;
    logic [31:0]      dma_data_rd_o;
    logic [31:0]      mem_d_addr_o, mem_d_data_wr_o;
    logic             mem_d_rd_o;
    logic [3:0]       mem_d_wr_o;
    logic             mem_d_cacheable_o;
    logic [TAG_W-1:0] mem_d_req_tag_o;
    logic             mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o;
    logic             mem_d_accept_i, mem_d_ack_i, mem_d_error_i;
    logic [31:0]      mem_d_data_rd_i;
    logic [TAG_W-1:0] mem_d_resp_tag_i;
    logic             protocol_err_o;

    int tests_run = 0;
    int tests_failed = 0;

    tcm_dport_arbiter #(.OUTSTANDING_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_d_addr_i(cpu_d_addr_i), .cpu_d_data_wr_i(cpu_d_data_wr_i),
        .cpu_d_rd_i(cpu_d_rd_i), .cpu_d_wr_i(cpu_d_wr_i),
        .cpu_d_cacheable_i(cpu_d_cacheable_i), .cpu_d_invalidate_i(cpu_d_invalidate_i),
        .cpu_d_writeback_i(cpu_d_writeback_i), .cpu_d_flush_i(cpu_d_flush_i),
        .cpu_d_req_tag_i(cpu_d_req_tag_i),
        .cpu_d_accept_o(cpu_d_accept_o), .cpu_d_ack_o(cpu_d_ack_o), .cpu_d_error_o(cpu_d_error_o),
        .cpu_d_data_rd_o(cpu_d_data_rd_o), .cpu_d_resp_tag_o(cpu_d_resp_tag_o),
        .dma_addr_i(dma_addr_i), .dma_data_wr_i(dma_data_wr_i),
        .dma_rd_i(dma_rd_i), .dma_wr_i(dma_wr_i),
        .dma_accept_o(dma_accept_o), .dma_ack_o(dma_ack_o), .dma_error_o(dma_error_o),
        .dma_data_rd_o(dma_data_rd_o),
        .mem_d_addr_o(mem_d_addr_o), .mem_d_data_wr_o(mem_d_data_wr_o),
        .mem_d_rd_o(mem_d_rd_o), .mem_d_wr_o(mem_d_wr_o),
        .mem_d_cacheable_o(mem_d_cacheable_o), .mem_d_req_tag_o(mem_d_req_tag_o),
        .mem_d_invalidate_o(mem_d_invalidate_o), .mem_d_writeback_o(mem_d_writeback_o),
        .mem_d_flush_o(mem_d_flush_o),
        .mem_d_accept_i(mem_d_accept_i), .mem_d_ack_i(mem_d_ack_i), .mem_d_error_i(mem_d_error_i),
        .mem_d_data_rd_i(mem_d_data_rd_i), .mem_d_resp_tag_i(mem_d_resp_tag_i),
        .protocol_err_o(protocol_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_d_addr_i = 32'h0; cpu_d_data_wr_i = 32'h0; cpu_d_rd_i = 1'b0; cpu_d_wr_i = 4'h0;
        cpu_d_cacheable_i = 1'b0; cpu_d_invalidate_i = 1'b0; cpu_d_writeback_i = 1'b0;
        cpu_d_flush_i = 1'b0; cpu_d_req_tag_i = '0;
        dma_addr_i = 32'h0; dma_data_wr_i = 32'h0; dma_rd_i = 1'b0; dma_wr_i = 4'h0;
        mem_d_accept_i = 1'b0; mem_d_ack_i = 1'b0; mem_d_error_i = 1'b0;
        mem_d_data_rd_i = 32'h0; mem_d_resp_tag_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1; cpu_d_rd_i = 1'b1; dma_wr_i = 4'hF; mem_d_accept_i = 1'b1; mem_d_ack_i = 1'b1;
        #1;
        tests_run++;
        if ({cpu_d_accept_o, dma_accept_o, mem_d_rd_o, mem_d_wr_o} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_req_outputs: got %b want 0", {cpu_d_accept_o, dma_accept_o, mem_d_rd_o, mem_d_wr_o});
        end
        tests_run++;
        if ({cpu_d_ack_o, dma_ack_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ack_outputs: got %b want 00", {cpu_d_ack_o, dma_ack_o});
        end
        step();
        rst_i = 1'b0;
        clear_inputs();
        #1;
        tests_run++;
        if (protocol_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_protocol_err: got %b want 0", protocol_err_o);
        end
        step();
    endtask

    task automatic test_cpu_read();
        clear_inputs();
        cpu_d_rd_i = 1'b1; cpu_d_addr_i = 32'h80; cpu_d_req_tag_i = 11'h005; mem_d_accept_i = 1'b1;
        #1;
        tests_run++;
        if ({cpu_d_accept_o, dma_accept_o, mem_d_rd_o} !== 3'b101) begin
            tests_failed++;
            $display("FAIL cpu_rd_accept: got %b want 101", {cpu_d_accept_o, dma_accept_o, mem_d_rd_o});
        end
        tests_run++;
        if (mem_d_addr_o !== 32'h80 || mem_d_req_tag_o !== 11'h005) begin
            tests_failed++;
            $display("FAIL cpu_rd_mux: addr %h tag %h want 00000080 005", mem_d_addr_o, mem_d_req_tag_o);
        end
        step();
        clear_inputs();
        mem_d_ack_i = 1'b1; mem_d_data_rd_i = 32'hDEADBEEF; mem_d_resp_tag_i = 11'h005;
        #1;
        tests_run++;
        if ({cpu_d_ack_o, dma_ack_o} !== 2'b10 || cpu_d_data_rd_o !== 32'hDEADBEEF || cpu_d_resp_tag_o !== 11'h005) begin
            tests_failed++;
            $display("FAIL cpu_rd_ack: ack %b data %h tag %h want 10 deadbeef 005",
                     {cpu_d_ack_o, dma_ack_o}, cpu_d_data_rd_o, cpu_d_resp_tag_o);
        end
        step();
        mem_d_ack_i = 1'b0;
    endtask

    task automatic test_round_robin();
        clear_inputs();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cpu_d_rd_i = (i < 6); dma_rd_i = (i < 6);
            mem_d_accept_i = 1'b1; mem_d_ack_i = (i >= 1);
            #1;
            if (i < 6) begin
                tests_run++;
                if (cpu_d_accept_o !== (i % 2 == 0) || dma_accept_o !== (i % 2 == 1)) begin
                    tests_failed++;
                    $display("FAIL rr_accept[%0d]: cpu %b dma %b want cpu %b", i, cpu_d_accept_o, dma_accept_o, (i % 2 == 0));
                end
            end
            if (i >= 1) begin
                tests_run++;
                if (cpu_d_ack_o !== ((i - 1) % 2 == 0) || dma_ack_o !== ((i - 1) % 2 == 1)) begin
                    tests_failed++;
                    $display("FAIL rr_ack[%0d]: cpu %b dma %b want cpu %b", i, cpu_d_ack_o, dma_ack_o, ((i - 1) % 2 == 0));
                end
            end
            step();
        end
        clear_inputs();
        #1;
        tests_run++;
        if (protocol_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_protocol_err: got %b want 0", protocol_err_o);
        end
    endtask

    task automatic test_lock();
        clear_inputs();
        do_reset();
        dma_wr_i = 4'hF; dma_addr_i = 32'h100; dma_data_wr_i = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) begin
                cpu_d_rd_i = 1'b1; cpu_d_addr_i = 32'h200; cpu_d_cacheable_i = 1'b1; cpu_d_req_tag_i = 11'h3A;
            end
            mem_d_accept_i = (i == 3);
            #1;
            tests_run++;
            if (mem_d_addr_o !== 32'h100 || mem_d_data_wr_o !== 32'h12345678 || mem_d_wr_o !== 4'hF
                || mem_d_rd_o !== 1'b0 || mem_d_cacheable_o !== 1'b0 || mem_d_req_tag_o !== 11'h0) begin
                tests_failed++;
                $display("FAIL lock_hold[%0d]: addr %h data %h wr %h rd %b cach %b tag %h", i,
                         mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_rd_o, mem_d_cacheable_o, mem_d_req_tag_o);
            end
            tests_run++;
            if (dma_accept_o !== (i == 3) || cpu_d_accept_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL lock_accept[%0d]: dma %b cpu %b want dma %b cpu 0", i, dma_accept_o, cpu_d_accept_o, (i == 3));
            end
            step();
        end
        dma_wr_i = 4'h0;
        #1;
        tests_run++;
        if (cpu_d_accept_o !== 1'b1 || mem_d_addr_o !== 32'h200 || mem_d_req_tag_o !== 11'h3A || mem_d_cacheable_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_cpu_next: acc %b addr %h tag %h cach %b", cpu_d_accept_o, mem_d_addr_o, mem_d_req_tag_o, mem_d_cacheable_o);
        end
        step();
        clear_inputs();
        mem_d_ack_i = 1'b1; mem_d_error_i = 1'b1;
        #1;
        tests_run++;
        if ({dma_ack_o, dma_error_o, cpu_d_ack_o, cpu_d_error_o} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL lock_ack_dma: got %b want 1100", {dma_ack_o, dma_error_o, cpu_d_ack_o, cpu_d_error_o});
        end
        step();
        mem_d_error_i = 1'b0;
        #1;
        tests_run++;
        if ({dma_ack_o, cpu_d_ack_o, cpu_d_error_o} !== 3'b010) begin
            tests_failed++;
            $display("FAIL lock_ack_cpu: got %b want 010", {dma_ack_o, cpu_d_ack_o, cpu_d_error_o});
        end
        step();
        mem_d_ack_i = 1'b0;
    endtask

    task automatic test_fifo_full();
        clear_inputs();
        do_reset();
        cpu_d_rd_i = 1'b1; mem_d_accept_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (cpu_d_accept_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL full_fill[%0d]: accept %b want 1", i, cpu_d_accept_o);
            end
            step();
        end
        #1;
        tests_run++;
        if (cpu_d_accept_o !== 1'b0 || mem_d_rd_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_block: accept %b rd %b want 0 0", cpu_d_accept_o, mem_d_rd_o);
        end
        step();
        mem_d_ack_i = 1'b1;
        #1;
        tests_run++;
        if (cpu_d_accept_o !== 1'b0 || cpu_d_ack_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_ack_cycle: accept %b ack %b want 0 1", cpu_d_accept_o, cpu_d_ack_o);
        end
        step();
        #1;
        tests_run++;
        if (cpu_d_accept_o !== 1'b1 || cpu_d_ack_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_push_pop: accept %b ack %b want 1 1", cpu_d_accept_o, cpu_d_ack_o);
        end
        step();
        mem_d_ack_i = 1'b0;
        #1;
        tests_run++;
        if (cpu_d_accept_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_refill: accept %b want 1", cpu_d_accept_o);
        end
        step();
        #1;
        tests_run++;
        if (cpu_d_accept_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_reblock: accept %b want 0", cpu_d_accept_o);
        end
        step();
        cpu_d_rd_i = 1'b0; mem_d_ack_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (cpu_d_ack_o !== (i < 4)) begin
                tests_failed++;
                $display("FAIL full_drain[%0d]: ack %b want %b", i, cpu_d_ack_o, (i < 4));
            end
            step();
        end
        mem_d_ack_i = 1'b0;
        #1;
        tests_run++;
        if (protocol_err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_overdrain_err: got %b want 1", protocol_err_o);
        end
    endtask

    task automatic test_protocol_err();
        clear_inputs();
        do_reset();
        mem_d_ack_i = 1'b1; cpu_d_rd_i = 1'b1; mem_d_accept_i = 1'b1;
        #1;
        tests_run++;
        if ({cpu_d_ack_o, dma_ack_o, cpu_d_accept_o, protocol_err_o} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL perr_same_cycle: got %b want 0010", {cpu_d_ack_o, dma_ack_o, cpu_d_accept_o, protocol_err_o});
        end
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (protocol_err_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL perr_sticky[%0d]: got %b want 1", i, protocol_err_o);
            end
            step();
        end
        do_reset();
        #1;
        tests_run++;
        if (protocol_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL perr_cleared: got %b want 0", protocol_err_o);
        end
    endtask

    task automatic test_reset_outstanding();
        clear_inputs();
        do_reset();
        cpu_d_rd_i = 1'b1; dma_rd_i = 1'b1; mem_d_accept_i = 1'b1;
        step();
        step();
        do_reset();
        #1;
        tests_run++;
        if (cpu_d_accept_o !== 1'b1 || dma_accept_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_out_rr: cpu %b dma %b want 1 0", cpu_d_accept_o, dma_accept_o);
        end
        step();
        clear_inputs();
        mem_d_ack_i = 1'b1; mem_d_data_rd_i = 32'hA5A5_0001;
        #1;
        tests_run++;
        if (cpu_d_ack_o !== 1'b1 || dma_ack_o !== 1'b0 || cpu_d_data_rd_o !== 32'hA5A5_0001) begin
            tests_failed++;
            $display("FAIL rst_out_ack: cpu %b dma %b data %h", cpu_d_ack_o, dma_ack_o, cpu_d_data_rd_o);
        end
        step();
        #1;
        tests_run++;
        if (cpu_d_ack_o !== 1'b0 || dma_ack_o !== 1'b0 || protocol_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_out_stale_ack: cpu %b dma %b err %b want 0 0 0", cpu_d_ack_o, dma_ack_o, protocol_err_o);
        end
        step();
        mem_d_ack_i = 1'b0;
        #1;
        tests_run++;
        if (protocol_err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_out_stale_err: got %b want 1", protocol_err_o);
        end
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        #1;
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_lock();
        test_fifo_full();
        test_protocol_err();
        test_reset_outstanding();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
